pll_lock_supervisor: RTL and testbench

//  Consumes the LOCK output of the ECP5 PLL wrappers and turns it into a clean system reset.

---
 rtl/pll_lock_supervisor.sv | 126 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises LOCK, pulses PLL RST on timeout or request,
// and releases the system reset only after lock has been continuously stable.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 250000,
    parameter int PLL_RST_CYCLES = 32,
    parameter int CNT_W          = 18
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rstn,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lost_lock_cnt,
    output logic [7:0] timeout_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   lock_s;
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [7:0]             lost_reg, lost_next;
    logic [7:0]             tout_reg, tout_next;

    assign lock_s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        lost_next  = lost_reg;
        tout_next  = tout_reg;
        if (force_relock) begin
            state_next = RESET_PLL;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                RESET_PLL: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still wins over the retry.
                    if (lock_s) begin
                        state_next = STABILIZE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = RESET_PLL;
                        cnt_next   = '0;
                        if (tout_reg != 8'hFF) tout_next = tout_reg + 8'd1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                        if (lost_reg != 8'hFF) lost_next = lost_reg + 8'd1;
                    end
                end
                default: begin
                    state_next = RESET_PLL;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            sync_reg  <= '0;
            state_reg <= RESET_PLL;
            cnt_reg   <= '0;
            lost_reg  <= 8'd0;
            tout_reg  <= 8'd0;
            pll_rst   <= 1'b1;
            sys_rstn  <= 1'b0;
            ready     <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            lost_reg  <= lost_next;
            tout_reg  <= tout_next;
            pll_rst   <= (state_next == RESET_PLL);
            sys_rstn  <= (state_next == RUN);
            ready     <= (state_next == RUN);
        end
    end

    assign state         = state_reg;
    assign lost_lock_cnt = lost_reg;
    assign timeout_cnt   = tout_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed lock/loss/timeout scenarios plus random
// LOCK waveforms, every cycle compared against a timestamp-based reference model.
module tb_pll_lock_supervisor;

    localparam int SYNC    = 2;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 100;
    localparam int RSTLEN  = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rstn;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lost_lock_cnt;
    logic [7:0] timeout_cnt;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT  (TIMEOUT),
        .PLL_RST_CYCLES(RSTLEN),
        .CNT_W         (8)
    ) dut (
        .clkin        (clk),
        .rstn         (rstn),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rstn     (sys_rstn),
        .ready        (ready),
        .state        (state),
        .lost_lock_cnt(lost_lock_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase plus the edge number it was entered at, and a queue
    // holding the LOCK samples still travelling through the synchroniser.
    int   n_edge  = 0;
    int   t_enter = 0;
    int   m_state = 0;
    int   m_lost  = 0;
    int   m_tout  = 0;
    logic q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n_edge, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic l, input logic f);
        int   age;
        logic lu;
        n_edge++;
        age = n_edge - t_enter - 1;
        lu  = q[0];
        if (!r) begin
            m_state = 0;
            t_enter = n_edge;
            m_lost  = 0;
            m_tout  = 0;
            q.delete();
            repeat (SYNC) q.push_back(1'b0);
        end else begin
            void'(q.pop_front());
            q.push_back(l);
            if (f) begin
                m_state = 0;
                t_enter = n_edge;
            end else if (m_state == 0) begin
                if (age == RSTLEN - 1) begin m_state = 1; t_enter = n_edge; end
            end else if (m_state == 1) begin
                if (lu) begin
                    m_state = 2; t_enter = n_edge;
                end else if (age == TIMEOUT - 1) begin
                    m_state = 0; t_enter = n_edge;
                    m_tout  = (m_tout < 255) ? m_tout + 1 : 255;
                end
            end else if (m_state == 2) begin
                if (!lu) begin
                    m_state = 1; t_enter = n_edge;
                end else if (age == STABLE - 1) begin
                    m_state = 3; t_enter = n_edge;
                end
            end else begin
                if (!lu) begin
                    m_state = 1; t_enter = n_edge;
                    m_lost  = (m_lost < 255) ? m_lost + 1 : 255;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic l, input logic f);
        rstn         = r;
        pll_locked   = l;
        force_relock = f;
        @(posedge clk);
        model_edge(r, l, f);
        @(negedge clk);
        check("state", 32'(state), 32'(m_state));
        check("pll_rst", 32'(pll_rst), 32'(m_state == 0));
        check("sys_rstn", 32'(sys_rstn), 32'(m_state == 3));
        check("ready", 32'(ready), 32'(m_state == 3));
        check("lost_lock_cnt", 32'(lost_lock_cnt), 32'(m_lost));
        check("timeout_cnt", 32'(timeout_cnt), 32'(m_tout));
    endtask

    task automatic run(input int n, input logic l);
        for (int i = 0; i < n; i++) step(1'b1, l, 1'b0);
    endtask

    initial begin
        int   seg;
        logic lvl;
        repeat (SYNC) q.push_back(1'b0);

        // Timeout rounds with no lock.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        run(3 * (RSTLEN + TIMEOUT), 1'b0);
        check("s1_timeout_cnt", 32'(timeout_cnt), 32'd3);
        check("s1_sys_rstn", 32'(sys_rstn), 32'd0);
        $display("scenario 1: timeout rounds, timeout_cnt=%0d", timeout_cnt);

        // Lock glitch during STABILIZE.
        run(RSTLEN, 1'b0);
        run(8, 1'b1);
        run(3, 1'b0);
        check("s3_state", 32'(state), 32'd1);
        check("s3_lost", 32'(lost_lock_cnt), 32'd0);
        $display("scenario 3: stabilize glitch, state=%0d lost=%0d", state, lost_lock_cnt);

        // Lock-path latency.
        run(3, 1'b1);
        check("s2_state_e2", 32'(state), 32'd2);
        run(15, 1'b1);
        check("s2_sys_rstn_e17", 32'(sys_rstn), 32'd0);
        run(1, 1'b1);
        check("s2_sys_rstn_e18", 32'(sys_rstn), 32'd1);
        check("s2_ready_e18", 32'(ready), 32'd1);
        check("s2_state_e18", 32'(state), 32'd3);
        $display("scenario 2: lock release, state=%0d sys_rstn=%0d", state, sys_rstn);

        // Loss-path latency and relock restart.
        run(2, 1'b0);
        check("s4_sys_rstn_e1", 32'(sys_rstn), 32'd1);
        run(1, 1'b0);
        check("s4_sys_rstn_e2", 32'(sys_rstn), 32'd0);
        check("s4_lost", 32'(lost_lock_cnt), 32'd1);
        run(18, 1'b1);
        check("s4_relock_e17", 32'(state), 32'd2);
        run(1, 1'b1);
        check("s4_relock_e18", 32'(state), 32'd3);
        $display("scenario 4: lock loss, lost=%0d state=%0d", lost_lock_cnt, state);

        // force_relock in RUN, then rstn mid-STABILIZE.
        step(1'b1, 1'b1, 1'b1);
        check("s6_force_state", 32'(state), 32'd0);
        check("s6_force_pll_rst", 32'(pll_rst), 32'd1);
        check("s6_force_sys_rstn", 32'(sys_rstn), 32'd0);
        run(RSTLEN + 4, 1'b1);
        check("s6_mid_stabilize", 32'(state), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        check("s6_rst_state", 32'(state), 32'd0);
        check("s6_rst_pll_rst", 32'(pll_rst), 32'd1);
        check("s6_rst_lost", 32'(lost_lock_cnt), 32'd0);
        check("s6_rst_tout", 32'(timeout_cnt), 32'd0);
        $display("scenario 6: force/reset, state=%0d lost=%0d tout=%0d",
                 state, lost_lock_cnt, timeout_cnt);

        // Saturation of both event counters.
        run(300 * (RSTLEN + TIMEOUT), 1'b0);
        check("s5_tout_sat", 32'(timeout_cnt), 32'd255);
        for (int i = 0; i < 300; i++) begin
            run(30, 1'b1);
            run(4, 1'b0);
        end
        check("s5_lost_sat", 32'(lost_lock_cnt), 32'd255);
        check("s5_tout_hold", 32'(timeout_cnt), 32'd255);
        $display("scenario 5: saturation, lost=%0d tout=%0d", lost_lock_cnt, timeout_cnt);

        // Random LOCK segments with sporadic force_relock and rstn.
        step(1'b0, 1'b0, 1'b0);
        seg = 0;
        lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                lvl = 1'($urandom_range(0, 1));
                seg = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 150));
            end
            seg--;
            step(($urandom_range(0, 255) != 0), lvl, ($urandom_range(0, 63) == 0));
        end
        $display("random: done, lost=%0d tout=%0d state=%0d", lost_lock_cnt, timeout_cnt, state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
